// File: rtl/hall_pkg.sv
// rtl/hall_pkg.sv - Hall code constants, tracker state enum and sequence helpers.
package hall_pkg;

  localparam logic [2:0] HALL_ILL_000 = 3'b000;
  localparam logic [2:0] HALL_ILL_111 = 3'b111;

  typedef enum logic [1:0] {IDLE, ACQUIRE, RUN, STALL} hall_state_e;

  function automatic logic is_legal(input logic [2:0] code);
    return (code != HALL_ILL_000) && (code != HALL_ILL_111);
  endfunction

  // Forward order: 001 -> 011 -> 010 -> 110 -> 100 -> 101 -> 001
  function automatic logic [2:0] next_fwd(input logic [2:0] code);
    case (code)
      3'b001:  return 3'b011;
      3'b011:  return 3'b010;
      3'b010:  return 3'b110;
      3'b110:  return 3'b100;
      3'b100:  return 3'b101;
      3'b101:  return 3'b001;
      default: return code;
    endcase
  endfunction

  function automatic logic [2:0] next_rev(input logic [2:0] code);
    case (code)
      3'b011:  return 3'b001;
      3'b010:  return 3'b011;
      3'b110:  return 3'b010;
      3'b100:  return 3'b110;
      3'b101:  return 3'b100;
      3'b001:  return 3'b101;
      default: return code;
    endcase
  endfunction

endpackage

// File: rtl/hall_debounce.sv
// rtl/hall_debounce.sv - Candidate/counter debouncer; stable asserts on the
// DEBOUNCE_CYCLES-th consecutive identical sample, counting the current input.
module hall_debounce #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] candidate,
  output logic             stable
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'((DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_ONE = CW'((DEBOUNCE_CYCLES > 1) ? 1 : 0);

  logic [WIDTH-1:0] cand_q;
  logic [CW-1:0]    cnt_q;

  // cnt_q holds how many samples of cand_q are already registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else if (din != cand_q) begin
      cand_q <= din;
      cnt_q  <= CNT_ONE;
    end else if (cnt_q != CNT_TOP) begin
      cnt_q  <= cnt_q + CW'(1);
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 1) begin : g_pass
      assign candidate = din;
      assign stable    = 1'b1;
    end else begin : g_count
      assign candidate = cand_q;
      assign stable    = (din == cand_q) && (cnt_q == CNT_TOP);
    end
  endgenerate

endmodule

// File: rtl/hall_sensor_frontend.sv
// rtl/hall_sensor_frontend.sv - Hall sync/debounce/validation, direction, period and stall
// tracking; HALL_PERIOD_AVG_EN reports the mean of the last 4 intervals.
module hall_sensor_frontend
  import hall_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PERIOD_W        = 24,
  parameter int STALL_LIMIT     = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          hall_in,
  input  logic                fault_clr,
  output logic [2:0]          hall_q,
  output logic                hall_valid,
  output logic                dir,
  output logic [PERIOD_W-1:0] period,
  output logic                period_stb,
  output logic                stall,
  output logic                fault_illegal,
  output logic                fault_seq
);

  localparam logic [PERIOD_W-1:0] STALL_CNT = PERIOD_W'(STALL_LIMIT);
  localparam logic [PERIOD_W-1:0] CNT_ONE   = PERIOD_W'(1);

  logic [2:0]          sync_q [SYNC_STAGES];
  logic [2:0]          cand;
  logic                stable;
  hall_state_e         state;
  logic [PERIOD_W-1:0] per_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= hall_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  hall_debounce #(
    .WIDTH           (3),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (sync_q[SYNC_STAGES-1]),
    .candidate (cand),
    .stable    (stable)
  );

  logic code_legal, change, edge_acc, is_fwd, is_rev, adjacent;
  logic counting, stall_hit, emit, leave_run;

  always_comb begin
    code_legal = is_legal(cand);
    change     = stable && (cand != hall_q);
    edge_acc   = change && code_legal;
    is_fwd     = (cand == next_fwd(hall_q));
    is_rev     = (cand == next_rev(hall_q));
    adjacent   = is_fwd || is_rev;
    counting   = (state == ACQUIRE) || (state == RUN);
    // an accepted edge always takes priority over the stall threshold
    stall_hit  = !edge_acc && counting && (per_cnt == STALL_CNT);
    emit       = edge_acc && adjacent && counting;
    leave_run  = (state == RUN) && (stall_hit || (edge_acc && !adjacent));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      hall_q        <= '0;
      hall_valid    <= 1'b0;
      dir           <= 1'b1;
      stall         <= 1'b0;
      fault_illegal <= 1'b0;
      fault_seq     <= 1'b0;
      per_cnt       <= '0;
    end else begin
      if (per_cnt != '1) per_cnt <= per_cnt + CNT_ONE;

      // fault setters below override a simultaneous clear
      if (fault_clr) begin
        fault_illegal <= 1'b0;
        fault_seq     <= 1'b0;
      end

      if (change && !code_legal) begin
        fault_illegal <= 1'b1;
        hall_valid    <= 1'b0;
      end else if (stable && code_legal) begin
        hall_valid    <= 1'b1;
      end

      if (edge_acc) begin
        hall_q  <= cand;
        per_cnt <= CNT_ONE;
        if (state == IDLE) begin
          state <= ACQUIRE;
        end else if (adjacent) begin
          dir   <= is_fwd;
          stall <= 1'b0;
          if (state == ACQUIRE)    state <= RUN;
          else if (state == STALL) state <= ACQUIRE;
        end else begin
          fault_seq <= 1'b1;
          stall     <= 1'b0;
          state     <= ACQUIRE;
        end
      end else if (stall_hit) begin
        state <= STALL;
        stall <= 1'b1;
      end
    end
  end

`ifdef HALL_PERIOD_AVG_EN
  logic [PERIOD_W-1:0] hist [3];
  logic [2:0]          hist_n;
  logic [PERIOD_W+1:0] sum;

  always_comb begin
    sum = {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]} + {2'b00, per_cnt};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period     <= '1;
      period_stb <= 1'b0;
      hist_n     <= '0;
      for (int i = 0; i < 3; i++) hist[i] <= '0;
    end else begin
      period_stb <= 1'b0;
      if (stall_hit) period <= '1;
      if (leave_run) begin
        hist_n <= '0;
      end else if (emit) begin
        hist[2] <= hist[1];
        hist[1] <= hist[0];
        hist[0] <= per_cnt;
        if (hist_n != 3'd4) hist_n <= hist_n + 3'd1;
        // three stored intervals plus the current one make a full window
        if (hist_n >= 3'd3) begin
          period     <= sum[PERIOD_W+1:2];
          period_stb <= 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period     <= '1;
      period_stb <= 1'b0;
    end else begin
      period_stb <= 1'b0;
      if (stall_hit) begin
        period <= '1;
      end else if (emit) begin
        period     <= per_cnt;
        period_stb <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hall_sensor_frontend.sv
// tb/tb_hall_sensor_frontend.sv - Scoreboard bench for hall_sensor_frontend.
module tb_hall_sensor_frontend;
  import hall_pkg::*;

  localparam int SYNC = 2;
  localparam int DEB  = 16;
  localparam int PW   = 24;
  localparam int LIM  = 3000;
  localparam int LAT  = SYNC + DEB;

  localparam logic [2:0] SEQ_CODE [6] = '{3'b011, 3'b010, 3'b110, 3'b010, 3'b011, 3'b001};
  localparam int         SEQ_PER  [6] = '{500, 500, 500, 300, 700, 450};
  localparam int         SEQ_WAIT [6] = '{500, 500, 300, 700, 450, 100};
  localparam logic       SEQ_DIR  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  typedef struct {
    logic [PW-1:0] period;
    logic          dir;
    logic [2:0]    code;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    hall_in;
  logic          fault_clr;
  logic [2:0]    hall_q;
  logic          hall_valid;
  logic          dir;
  logic [PW-1:0] period;
  logic          period_stb;
  logic          stall;
  logic          fault_illegal;
  logic          fault_seq;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q [$];
  exp_t mon_e;

  hall_sensor_frontend #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .PERIOD_W        (PW),
    .STALL_LIMIT     (LIM)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hall_in       (hall_in),
    .fault_clr     (fault_clr),
    .hall_q        (hall_q),
    .hall_valid    (hall_valid),
    .dir           (dir),
    .period        (period),
    .period_stb    (period_stb),
    .stall         (stall),
    .fault_illegal (fault_illegal),
    .fault_seq     (fault_seq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] code, input bit emits, input int per, input logic d);
    exp_t e;
    hall_in = code;
    if (emits) begin
      e.period = PW'(per);
      e.dir    = d;
      e.code   = code;
      sb_q.push_back(e);
    end
  endtask

  task automatic pulse_clr();
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && period_stb === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_period_stb: got period=%0d expected no strobe", period);
      end else begin
        mon_e = sb_q.pop_front();
        chk("stb_period", 32'(period), 32'(mon_e.period));
        chk("stb_dir", 32'(dir), 32'(mon_e.dir));
        chk("stb_hall_q", 32'(hall_q), 32'(mon_e.code));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    hall_in   = 3'b000;
    fault_clr = 1'b0;
    tick(3);
    chk("rst_hall_q", 32'(hall_q), 32'h0);
    chk("rst_hall_valid", 32'(hall_valid), 32'h0);
    chk("rst_dir", 32'(dir), 32'h1);
    chk("rst_period", 32'(period), 32'hFF_FFFF);
    chk("rst_period_stb", 32'(period_stb), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_faults", 32'({fault_illegal, fault_seq}), 32'h0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    rst_n = 1'b1;
    tick(5);

    // first legal code: accepted exactly LAT cycles after the pin change
    drive(3'b001, 1'b0, 0, 1'b1);
    tick(LAT - 1);
    chk("acq_early_valid", 32'(hall_valid), 32'h0);
    chk("acq_early_hall_q", 32'(hall_q), 32'h0);
    tick(1);
    chk("acq_hall_q", 32'(hall_q), 32'h1);
    chk("acq_valid", 32'(hall_valid), 32'h1);
    chk("acq_state", 32'(dut.state), 32'(ACQUIRE));
    tick(500 - LAT);

    // forward run then reversal
    for (int i = 0; i < 6; i++) begin
      drive(SEQ_CODE[i], 1'b1, SEQ_PER[i], SEQ_DIR[i]);
      tick(LAT + 1);
      chk("seq_hall_q", 32'(hall_q), 32'(SEQ_CODE[i]));
      chk("seq_dir", 32'(dir), 32'(SEQ_DIR[i]));
      tick(SEQ_WAIT[i] - LAT - 1);
    end
    chk("run_state", 32'(dut.state), 32'(RUN));

    // short glitch is filtered
    drive(3'b011, 1'b0, 0, 1'b0);
    tick(10);
    drive(3'b001, 1'b0, 0, 1'b0);
    tick(60);
    chk("glitch_hall_q", 32'(hall_q), 32'h1);
    chk("glitch_valid", 32'(hall_valid), 32'h1);

    // illegal code, clear racing an active fault, recovery
    drive(3'b111, 1'b0, 0, 1'b0);
    tick(LAT + 1);
    chk("ill_fault", 32'(fault_illegal), 32'h1);
    chk("ill_valid", 32'(hall_valid), 32'h0);
    chk("ill_hall_q", 32'(hall_q), 32'h1);
    pulse_clr();
    chk("ill_clr_loses", 32'(fault_illegal), 32'h1);
    drive(3'b001, 1'b0, 0, 1'b0);
    tick(LAT + 1);
    chk("ill_back_valid", 32'(hall_valid), 32'h1);
    chk("ill_back_sticky", 32'(fault_illegal), 32'h1);
    pulse_clr();
    chk("ill_cleared", 32'(fault_illegal), 32'h0);
    chk("seq_fault_idle", 32'(fault_seq), 32'h0);

    // non-adjacent jump, then stall from ACQUIRE
    drive(3'b110, 1'b0, 0, 1'b0);
    tick(LAT + 1);
    chk("jump_fault_seq", 32'(fault_seq), 32'h1);
    chk("jump_hall_q", 32'(hall_q), 32'h6);
    chk("jump_state", 32'(dut.state), 32'(ACQUIRE));
    chk("jump_period_held", 32'(period), 32'd450);
    chk("jump_dir_held", 32'(dir), 32'h0);
    tick(LIM - 2);
    chk("stall_early", 32'(stall), 32'h0);
    tick(1);
    chk("stall_set", 32'(stall), 32'h1);
    chk("stall_period", 32'(period), 32'hFF_FFFF);
    chk("stall_state", 32'(dut.state), 32'(STALL));

    // adjacent edge leaves stall silently; the next one emits again
    drive(3'b100, 1'b0, 0, 1'b1);
    tick(LAT + 2);
    chk("unstall_stall", 32'(stall), 32'h0);
    chk("unstall_state", 32'(dut.state), 32'(ACQUIRE));
    chk("unstall_dir", 32'(dir), 32'h1);
    chk("unstall_period", 32'(period), 32'hFF_FFFF);
    tick(400 - LAT - 2);
    drive(3'b101, 1'b1, 400, 1'b1);
    tick(LAT + 2);
    chk("resume_state", 32'(dut.state), 32'(RUN));

    // asynchronous reset mid-cycle
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_hall_q", 32'(hall_q), 32'h0);
    chk("arst_valid", 32'(hall_valid), 32'h0);
    chk("arst_period", 32'(period), 32'hFF_FFFF);
    chk("arst_fault_seq", 32'(fault_seq), 32'h0);
    chk("arst_state", 32'(dut.state), 32'(IDLE));
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
